// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick from an eligibility mask.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last2,
    output logic [1:0] pick
);

    // last2 set means requester 2 went most recently, so 1 wins a tie
    always_comb begin
        pick = 2'b00;
        case (elig)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last2 ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two single-access requesters onto one async-read RAM port.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              req2,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic              gnt1,
    output logic              gnt2,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic              qv1,
    output logic              qv2,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_e            state_q, state_d;
    logic              last2_q, last2_d;
    logic [DATA_W-1:0] q1_q, q1_d;
    logic [DATA_W-1:0] q2_q, q2_d;
    logic              qv1_q, qv1_d;
    logic              qv2_q, qv2_d;

    logic       served1, served2;
    logic [1:0] elig;
    logic [1:0] pick;

    assign served1 = (state_q == SERVE1);
    assign served2 = (state_q == SERVE2);

    // The requester served this cycle sits out the next pick
    assign elig = {req2 & ~served2, req1 & ~served1};

    rr_arb2 u_rr (
        .elig  (elig),
        .last2 (last2_q),
        .pick  (pick)
    );

    always_comb begin
        state_d = IDLE;
        last2_d = last2_q;
        if (pick[0]) begin
            state_d = SERVE1;
            last2_d = 1'b0;
        end else if (pick[1]) begin
            state_d = SERVE2;
            last2_d = 1'b1;
        end
        qv1_d = served1 & ~we1;
        qv2_d = served2 & ~we2;
        q1_d  = qv1_d ? ram_q : q1_q;
        q2_d  = qv2_d ? ram_q : q2_q;
    end

    always_comb begin
        ram_a  = '0;
        ram_d  = '0;
        ram_we = 1'b0;
        if (served1) begin
            ram_a  = a1;
            ram_d  = d1;
            ram_we = we1;
        end else if (served2) begin
            ram_a  = a2;
            ram_d  = d2;
            ram_we = we2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last2_q <= 1'b1;
            q1_q    <= '0;
            q2_q    <= '0;
            qv1_q   <= 1'b0;
            qv2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last2_q <= last2_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            qv1_q   <= qv1_d;
            qv2_q   <= qv2_d;
        end
    end

    assign gnt1 = served1;
    assign gnt2 = served2;
    assign q1   = q1_q;
    assign q2   = q2_q;
    assign qv1  = qv1_q;
    assign qv2  = qv2_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed vector bench for ram_port_arbiter with a behavioural RAM.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst;
    logic       req1, req2, we1, we2;
    logic [6:0] a1, a2;
    logic [7:0] d1, d2;
    logic       gnt1, gnt2, qv1, qv2;
    logic [7:0] q1, q2;
    logic [6:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic [7:0] ram_q;

    logic [7:0] mem [128];
    logic       mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       r1, w1;
        logic [6:0] a1;
        logic [7:0] d1;
        logic       r2, w2;
        logic [6:0] a2;
        logic [7:0] d2;
        logic       g1, g2, v1, v2, we;
        logic [6:0] ra;
        logic [7:0] rd, q1, q2;
    } vec_t;

    vec_t vq[$];

    ram_port_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req1   (req1),
        .req2   (req2),
        .we1    (we1),
        .we2    (we2),
        .a1     (a1),
        .a2     (a2),
        .d1     (d1),
        .d2     (d2),
        .gnt1   (gnt1),
        .gnt2   (gnt2),
        .q1     (q1),
        .q2     (q2),
        .qv1    (qv1),
        .qv2    (qv2),
        .ram_a  (ram_a),
        .ram_d  (ram_d),
        .ram_we (ram_we),
        .ram_q  (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_q = mem[ram_a];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
    end

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic row(input logic rs,
                       input logic r1, input logic w1, input logic [6:0] x1,
                       input logic [7:0] y1,
                       input logic r2, input logic w2, input logic [6:0] x2,
                       input logic [7:0] y2,
                       input logic g1, input logic g2,
                       input logic v1, input logic v2, input logic we,
                       input logic [6:0] ra, input logic [7:0] rd,
                       input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.rst = rs; v.r1 = r1; v.w1 = w1; v.a1 = x1; v.d1 = y1;
        v.r2 = r2; v.w2 = w2; v.a2 = x2; v.d2 = y2;
        v.g1 = g1; v.g2 = g2; v.v1 = v1; v.v2 = v2; v.we = we;
        v.ra = ra; v.rd = rd; v.q1 = e1; v.q2 = e2;
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        {req1, req2, we1, we2} = '0;
        a1 = '0; a2 = '0; d1 = '0; d2 = '0;

        // inputs held during a cycle -> outputs seen in that same cycle
        row(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'h00);
        row(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 1,0,0,0,1,7'h05,8'hA5,8'h00,8'h00);
        row(0, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'h00);
        row(0, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 0,1,0,0,0,7'h05,8'h00,8'h00,8'h00);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,1,0,7'h00,8'h00,8'h00,8'hA5);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h05,8'h00,8'h00,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'hA5,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h05,8'h00,8'hA5,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'hA5,8'hA5);
        row(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h05,8'h00,8'hA5,8'hA5);
        row(0, 0,0,7'h05,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'hA5,8'hA5);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'hA5,8'hA5);
        row(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'h00);
        row(0, 1,0,7'h05,8'h00, 1,0,7'h06,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h00,8'h00);
        row(0, 1,0,7'h05,8'h00, 1,0,7'h06,8'h00, 1,0,0,0,0,7'h05,8'h00,8'h00,8'h00);
        row(0, 1,0,7'h05,8'h00, 1,0,7'h06,8'h00, 0,1,1,0,0,7'h06,8'h00,8'hA5,8'h00);
        row(0, 1,0,7'h05,8'h00, 1,0,7'h06,8'h00, 1,0,0,1,0,7'h05,8'h00,8'hA5,8'h5C);
        row(0, 1,0,7'h05,8'h00, 1,0,7'h06,8'h00, 0,1,1,0,0,7'h06,8'h00,8'hA5,8'h5C);
        row(0, 0,0,7'h05,8'h00, 0,0,7'h06,8'h00, 1,0,0,1,0,7'h05,8'h00,8'hA5,8'h5C);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'hA5,8'h5C);
        row(0, 1,0,7'h7F,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'hA5,8'h5C);
        row(0, 1,0,7'h7F,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h7F,8'h00,8'hA5,8'h5C);
        row(0, 0,0,7'h00,8'h00, 1,1,7'h7F,8'h3C, 0,0,1,0,0,7'h00,8'h00,8'h25,8'h5C);
        row(0, 0,0,7'h00,8'h00, 1,1,7'h7F,8'h3C, 0,1,0,0,1,7'h7F,8'h3C,8'h25,8'h5C);
        row(0, 1,0,7'h7F,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h25,8'h5C);
        row(0, 1,0,7'h7F,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h7F,8'h00,8'h25,8'h5C);
        row(0, 1,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'h3C,8'h5C);
        row(0, 1,0,7'h00,8'h00, 0,0,7'h00,8'h00, 1,0,0,0,0,7'h00,8'h00,8'h3C,8'h5C);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,1,0,0,7'h00,8'h00,8'h5A,8'h5C);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h5A,8'h5C);
        row(0, 1,0,7'h01,8'h00, 1,1,7'h10,8'hFF, 0,0,0,0,0,7'h00,8'h00,8'h5A,8'h5C);
        row(0, 0,0,7'h00,8'h00, 1,1,7'h10,8'hFF, 0,1,0,0,1,7'h10,8'hFF,8'h5A,8'h5C);
        row(0, 1,0,7'h01,8'h00, 1,0,7'h02,8'h00, 0,0,0,0,0,7'h00,8'h00,8'h5A,8'h5C);
        row(0, 1,0,7'h01,8'h00, 1,0,7'h02,8'h00, 1,0,0,0,0,7'h01,8'h00,8'h5A,8'h5C);
        row(0, 0,0,7'h01,8'h00, 1,0,7'h02,8'h00, 0,1,1,0,0,7'h02,8'h00,8'h5B,8'h5C);
        row(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,1,0,7'h00,8'h00,8'h5B,8'h58);

        #2;
        chk("rst_gnt1", -1, 32'(gnt1), 32'd0);
        chk("rst_gnt2", -1, 32'(gnt2), 32'd0);
        chk("rst_we", -1, 32'(ram_we), 32'd0);
        chk("rst_qv", -1, 32'({qv1, qv2}), 32'd0);
        chk("rst_q", -1, 32'({q1, q2}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            rst = vq[i].rst;
            req1 = vq[i].r1; we1 = vq[i].w1; a1 = vq[i].a1; d1 = vq[i].d1;
            req2 = vq[i].r2; we2 = vq[i].w2; a2 = vq[i].a2; d2 = vq[i].d2;
            #2;
            chk("gnt1", i, 32'(gnt1), 32'(vq[i].g1));
            chk("gnt2", i, 32'(gnt2), 32'(vq[i].g2));
            chk("qv1", i, 32'(qv1), 32'(vq[i].v1));
            chk("qv2", i, 32'(qv2), 32'(vq[i].v2));
            chk("ram_we", i, 32'(ram_we), 32'(vq[i].we));
            chk("ram_a", i, 32'(ram_a), 32'(vq[i].ra));
            chk("ram_d", i, 32'(ram_d), 32'(vq[i].rd));
            chk("q1", i, 32'(q1), 32'(vq[i].q1));
            chk("q2", i, 32'(q2), 32'(vq[i].q2));
            @(posedge clk);
            #1;
        end

        // reset dropped mid-cycle onto a SERVE2 write
        req2 = 1'b1; we2 = 1'b1; a2 = 7'h20; d2 = 8'h77;
        @(posedge clk);
        #1;
        chk("abort_gnt2_pre", 100, 32'(gnt2), 32'd1);
        chk("abort_we_pre", 100, 32'(ram_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_gnt2", 101, 32'(gnt2), 32'd0);
        chk("abort_we", 101, 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req2 = 1'b0; we2 = 1'b0;
        chk("abort_mem", 102, 32'(mem[7'h20]), 32'h7A);

        // reset during a read suppresses its qv pulse
        req1 = 1'b1; we1 = 1'b0; a1 = 7'h7F;
        @(posedge clk);
        #1;
        chk("rdabort_gnt1", 103, 32'(gnt1), 32'd1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rdabort_qv1", 104, 32'(qv1), 32'd0);
        chk("rdabort_q1", 104, 32'(q1), 32'd0);
        rst = 1'b0;
        req1 = 1'b1; req2 = 1'b1; we1 = 1'b0; we2 = 1'b0;
        a1 = 7'h01; a2 = 7'h02;
        @(posedge clk);
        #1;
        chk("post_rst_gnt1", 105, 32'(gnt1), 32'd1);
        chk("post_rst_gnt2", 105, 32'(gnt2), 32'd0);
        req1 = 1'b0; req2 = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, RAM address width (128 words).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Ports req1/req2, input, 1 each: requester n asks for one RAM access; held high with a/d/we stable until gnt seen.
REQ-006 Ports we1/we2, input, 1 each: 1 = write, 0 = read, for the pending request.
REQ-007 Ports a1/a2, input, ADDR_W each: request address.
REQ-008 Ports d1/d2, input, DATA_W each: write data.
REQ-009 Ports gnt1/gnt2, output, 1 each: access performed this cycle; one-cycle pulse, registered.
REQ-010 Ports q1/q2, output, DATA_W each: read data, registered, held until next read by same requester.
REQ-011 Ports qv1/qv2, output, 1 each: q valid, one-cycle pulse.
REQ-012 Port ram_a, output, ADDR_W: address to RAM.
REQ-013 Port ram_d, output, DATA_W: write data to RAM.
REQ-014 Port ram_we, output, 1: RAM write enable.
REQ-015 Port ram_q, input, DATA_W: RAM read data, combinational from ram_a (asynchronous read).

Function
REQ-016 FSM states IDLE, SERVE1, SERVE2; gnt1 = (state==SERVE1), gnt2 = (state==SERVE2); never both high.
REQ-017 Each edge: eligible set = asserted reqs minus the requester served in the cycle just ending; none -> IDLE; one -> SERVE of that one; both -> round-robin.
REQ-018 Round-robin: on contention grant the requester not served most recently; pointer updates on every grant.
REQ-019 Latency: req high at edge N (from IDLE) -> gnt high cycle N..N+1; access occurs in the gnt cycle.
REQ-020 During SERVEn: ram_a=an, ram_d=dn, ram_we=wen; outside SERVE: ram_we=0, ram_a/ram_d=0.
REQ-021 Read (wen=0) in SERVEn: at edge ending cycle, qn <= ram_q, qvn=1 for exactly the following cycle.
REQ-022 Write: no qv pulse; qn unchanged.
REQ-023 Both requesting continuously -> strict alternation, one access per cycle, 100% RAM utilisation.
REQ-024 Single requester with req held high -> grant every other cycle (served req ignored one edge).
REQ-025 Requester dropping req before gnt: request withdrawn, no access, no pointer change.
REQ-026 Same address, write by one then read by other in consecutive grants -> read returns new data.

Reset
REQ-027 rst high: immediately state=IDLE, gnt1=gnt2=0, ram_we=0, qv1=qv2=0, q1=q2=0, pointer favours requester 1.
REQ-028 Reset mid-access: write aborted (ram_we drops asynchronously), pending qv suppressed; first grant after release follows REQ-017 with requester 1 priority.

Structure
REQ-029 Shared package holds ADDR_W/DATA_W defaults and FSM state encoding (2-bit IDLE=0, SERVE1=1, SERVE2=2).
REQ-030 One sub-module, rr_arb2: 2-way round-robin pick from eligible mask and last-served pointer; RAM remains external.

Verification
REQ-031 req1 write a=0x05 d=0xA5 alone -> gnt1 one cycle, ram_we=1 ram_a=0x05 ram_d=0xA5 that cycle, qv1 never high.
REQ-032 Then req2 read a=0x05 -> gnt2, next cycle qv2=1, q2=0xA5.
REQ-033 req1 and req2 both raised same edge after reset, held -> gnt1,gnt2,gnt1,gnt2 alternating, one grant per cycle.
REQ-034 req1 held high alone 6 cycles -> gnt1 pattern 1,0,1,0,1,0.
REQ-035 rst asserted mid-cycle during SERVE2 write -> gnt2 and ram_we drop before next edge; memory at target address unchanged.
REQ-036 Read 0x7F then write 0x7F=0x3C by other requester, then read -> q shows old value, then 0x3C; address wrap 0x7F->0x00 unaffected.
